// File: rtl/pipelined_adder.sv
// pipelined_adder: two's-complement adder/subtractor whose carry chain is cut
// into STAGES equal segments, one register stage per segment, with valid/ready
// handshakes on both sides. Optional feature macro: PIPE_ADDER_SAT_EN
// (saturate sum on signed overflow in the final stage).
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SEG = WIDTH / STAGES;

  logic [STAGES-1:0] vld_vec_s;
  logic [STAGES-1:0] adv_s;

  // Advance chain: a stage moves when it is empty or its successor moves.
  always_comb begin
    adv_s = {STAGES{1'b0}};
    adv_s[STAGES-1] = !vld_vec_s[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_s[k] = !vld_vec_s[k] || adv_s[k+1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : gen_stage
      localparam int SRC_W = WIDTH - g * SEG;  // operand bits not yet added
      localparam int RES_W = (g + 1) * SEG;    // result bits known after this stage

      logic             src_v_s;
      logic             src_c_s;
      logic [SRC_W-1:0] src_a_s;
      logic [SRC_W-1:0] src_b_s;
      logic [SEG:0]     seg_s;
      logic [RES_W-1:0] cat_s;
      logic [RES_W-1:0] nxt_res_s;
      logic             load_s;
      logic             vld_q, vld_d;
      logic             c_q, c_d;
      logic [RES_W-1:0] res_q, res_d;

      if (g == 0) begin : gen_src
        // First stage takes operands from the port and folds sub into B and carry-in.
        always_comb begin
          src_v_s = in_valid;
          src_a_s = a;
          src_b_s = sub ? ~b : b;
          src_c_s = sub;
        end
        // First stage result is just its own segment.
        always_comb begin
          cat_s = seg_s[SEG-1:0];
        end
      end else begin : gen_src
        // Later stages consume the skewed operands and carry of the previous stage.
        always_comb begin
          src_v_s = gen_stage[g-1].vld_q;
          src_a_s = gen_stage[g-1].gen_skew.ua_q;
          src_b_s = gen_stage[g-1].gen_skew.ub_q;
          src_c_s = gen_stage[g-1].c_q;
        end
        // Append this segment above the lower bits already computed.
        always_comb begin
          cat_s = {seg_s[SEG-1:0], gen_stage[g-1].res_q};
        end
      end

      // Add this stage's segment using the carry handed down from below.
      always_comb begin
        seg_s = {1'b0, src_a_s[SEG-1:0]} + {1'b0, src_b_s[SEG-1:0]} + {{SEG{1'b0}}, src_c_s};
      end

      assign load_s = adv_s[g] && src_v_s;

      if (g == STAGES - 1) begin : gen_last
        logic ovf_q, ovf_d, ovf_raw_s;
        // Signed overflow from the operand MSBs and the fresh result MSB; optional saturation.
        always_comb begin
          ovf_raw_s = (src_a_s[SRC_W-1] == src_b_s[SRC_W-1]) &&
                      (cat_s[RES_W-1] != src_a_s[SRC_W-1]);
`ifdef PIPE_ADDER_SAT_EN
          if (ovf_raw_s) begin
            nxt_res_s = src_a_s[SRC_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
          end else begin
            nxt_res_s = cat_s;
          end
`else
          nxt_res_s = cat_s;
`endif
          if (load_s) begin
            ovf_d = ovf_raw_s;
          end else begin
            ovf_d = ovf_q;
          end
        end
        // Overflow flag register, held while the output is stalled.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf_q <= 1'b0;
          end else begin
            ovf_q <= ovf_d;
          end
        end
      end else begin : gen_skew
        logic [SRC_W-SEG-1:0] ua_q, ua_d, ub_q, ub_d;
        // Carry the not-yet-added operand bits alongside the partial sum.
        always_comb begin
          nxt_res_s = cat_s;
          if (load_s) begin
            ua_d = src_a_s[SRC_W-1:SEG];
            ub_d = src_b_s[SRC_W-1:SEG];
          end else begin
            ua_d = ua_q;
            ub_d = ub_q;
          end
        end
        // Skewed operand registers.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ua_q <= {(SRC_W-SEG){1'b0}};
            ub_q <= {(SRC_W-SEG){1'b0}};
          end else begin
            ua_q <= ua_d;
            ub_q <= ub_d;
          end
        end
      end

      // Next-state for the valid bit, partial result and segment carry.
      always_comb begin
        if (adv_s[g]) begin
          vld_d = src_v_s;
        end else begin
          vld_d = vld_q;
        end
        if (load_s) begin
          res_d = nxt_res_s;
          c_d   = seg_s[SEG];
        end else begin
          res_d = res_q;
          c_d   = c_q;
        end
      end

      // Stage registers; reset discards any in-flight operation.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= 1'b0;
          c_q   <= 1'b0;
          res_q <= {RES_W{1'b0}};
        end else begin
          vld_q <= vld_d;
          c_q   <= c_d;
          res_q <= res_d;
        end
      end

      assign vld_vec_s[g] = vld_q;
    end
  endgenerate

  assign in_ready  = adv_s[0];
  assign out_valid = gen_stage[STAGES-1].vld_q;
  assign sum       = gen_stage[STAGES-1].res_q;
  assign carry_out = gen_stage[STAGES-1].c_q;
  assign overflow  = gen_stage[STAGES-1].gen_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: main instance WIDTH=32/STAGES=4,
// plus WIDTH=32/STAGES=1 and WIDTH=8/STAGES=2 instances for the small configs.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
  logic [31:0] a, b, sum;

  logic        v1, ir1, s1, ov1, r1, c1, o1;
  logic [31:0] a1, b1, sum1;
  logic        v2, ir2, s2, ov2, r2, c2, o2;
  logic [7:0]  a2, b2, sum2;

  int errors = 0;
  int checks = 0;

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow));

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .a(a1), .b(b1),
    .sub(s1), .out_valid(ov1), .out_ready(r1), .sum(sum1),
    .carry_out(c1), .overflow(o1));

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .a(a2), .b(b2),
    .sub(s2), .out_valid(ov2), .out_ready(r2), .sum(sum2),
    .carry_out(c2), .overflow(o2));

  // Reference: exact signed arithmetic for overflow/sum, unsigned compare for carry.
  function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint sx, sy, r;
    logic [32:0] u;
    logic [31:0] res;
    logic ov, cy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = s ? (sx - sy) : (sx + sy);
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    u  = {1'b0, x} + {1'b0, y};
    cy = s ? (x >= y) : u[32];
    res = r[31:0];
`ifdef PIPE_ADDER_SAT_EN
    if (ov) res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {ov, cy, res};
  endfunction

  // Issue one operation on the empty main pipeline and wait for its result.
  task automatic run_single(input logic [31:0] ia, input logic [31:0] ib, input logic is,
                            output logic [31:0] os, output logic oc, output logic oo, output int lat);
    in_valid = 1'b1; a = ia; b = ib; sub = is; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    os = sum; oc = carry_out; oo = overflow;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || ov1 !== 1'b0 || ov2 !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b%b%b, want 000", out_valid, ov1, ov2);
    end
    checks++;
    if ({sum, carry_out, overflow} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got sum=%h c=%b o=%b, want all zero", sum, carry_out, overflow);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flags();
    logic [31:0] ta [4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    logic [31:0] tb [4] = '{32'h0000_0001, 32'h8000_0000, 32'h0000_0005, 32'h0000_0001};
    logic        ts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
`ifdef PIPE_ADDER_SAT_EN
    logic [31:0] es [4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0000_0000};
`else
    logic [31:0] es [4] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'h0000_0000};
`endif
    logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] os;
    logic oc, oo;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_single(ta[i], tb[i], ts[i], os, oc, oo, lat);
      checks++;
      if (os !== es[i] || oc !== ec[i] || oo !== eo[i]) begin
        errors++;
        $display("FAIL flags[%0d]: got sum=%h c=%b o=%b, want sum=%h c=%b o=%b",
                 i, os, oc, oo, es[i], ec[i], eo[i]);
      end
      checks++;
      if (lat != 4) begin
        errors++; $display("FAIL latency[%0d]: got %0d, want 4", i, lat);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, got;
    logic accepted, snap, stable;
    logic [33:0] hold;
    acc = 0; got = 0; snap = 1'b0; stable = 1'b1; hold = 34'd0;
    out_ready = 1'b0; sub = 1'b0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (acc < 8); a = 32'(acc); b = 32'(acc) * 32'h10;
      #1;
      if (out_valid) begin
        if (!snap) begin
          snap = 1'b1; hold = {overflow, carry_out, sum};
        end else if ({overflow, carry_out, sum} !== hold) begin
          stable = 1'b0;
        end
      end
      accepted = in_valid && in_ready;
      @(posedge clk); #1;
      if (accepted) acc++;
    end
    checks++;
    if (acc != 4 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_accepts: got %0d (in_ready=%b), want 4 (in_ready=0)", acc, in_ready);
    end
    checks++;
    if (!snap || !stable || hold !== 34'd0) begin
      errors++; $display("FAIL bp_stall_hold: got snap=%b stable=%b held=%h, want 1 1 0", snap, stable, hold);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 8; c++) begin
      in_valid = (acc < 8); a = 32'(acc); b = 32'(acc) * 32'h10;
      #1;
      accepted = in_valid && in_ready;
      if (out_valid) begin
        checks++;
        if (sum !== 32'(got) * 32'h11 || carry_out !== 1'b0 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL bp_result[%0d]: got sum=%h c=%b o=%b, want sum=%h c=0 o=0",
                   got, sum, carry_out, overflow, 32'(got) * 32'h11);
        end
        got++;
      end
      @(posedge clk); #1;
      if (accepted) acc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 8 || acc != 8) begin
      errors++; $display("FAIL bp_count: got %0d results/%0d accepts, want 8/8", got, acc);
    end
  endtask

  task automatic test_streaming();
    logic [33:0] expq[$];
    logic [33:0] e;
    int sent, got, first, gaps, cyc, notready;
    sent = 0; got = 0; first = -1; gaps = 0; cyc = 0; notready = 0;
    out_ready = 1'b1;
    while (got < 100 && cyc < 300) begin
      if (sent < 100) begin
        in_valid = 1'b1;
        a   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
        b   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
        sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid) begin
        if (in_ready) begin
          expq.push_back(model32(a, b, sub)); sent++;
        end else begin
          notready++;
        end
      end
      if (out_valid) begin
        if (first < 0) first = cyc;
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL stream_extra: got unexpected result %h, want none", sum);
        end else begin
          e = expq.pop_front();
          if ({overflow, carry_out, sum} !== e) begin
            errors++;
            $display("FAIL stream[%0d]: got o=%b c=%b sum=%h, want o=%b c=%b sum=%h",
                     got, overflow, carry_out, sum, e[33], e[32], e[31:0]);
          end
        end
        got++;
      end else if (first >= 0) begin
        gaps++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got != 100 || notready != 0 || gaps != 0 || first != 4) begin
      errors++;
      $display("FAIL stream_rate: got results=%0d stalls=%0d gaps=%0d first=%0d, want 100 0 0 4",
               got, notready, gaps, first);
    end
  endtask

  task automatic test_reset_midstream();
    int stale, lat;
    logic [31:0] os;
    logic oc, oo;
    out_ready = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'(i + 1); b = 32'h100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== 32'h101) begin
      errors++; $display("FAIL mid_pre: got v=%b sum=%h, want v=1 sum=00000101", out_valid, sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum, carry_out, overflow} !== 35'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b sum=%h c=%b o=%b, want all zero", out_valid, sum, carry_out, overflow);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL mid_stale: got %0d stale results, want 0", stale);
    end
    run_single(32'd12, 32'd25, 1'b0, os, oc, oo, lat);
    checks++;
    if (os !== 32'h25 || lat != 4 || oc !== 1'b0 || oo !== 1'b0) begin
      errors++; $display("FAIL mid_after: got sum=%h lat=%0d, want sum=00000025 lat=4", os, lat);
    end
  endtask

  task automatic test_small_configs();
    logic [31:0] xa1 [2] = '{32'd12, 32'h8000_0000};
    logic [31:0] xb1 [2] = '{32'd25, 32'h0000_0001};
    logic        xs1 [2] = '{1'b0, 1'b1};
`ifdef PIPE_ADDER_SAT_EN
    logic [31:0] es1 [2] = '{32'h25, 32'h8000_0000};
    logic [7:0]  es2 [2] = '{8'h25, 8'h7F};
`else
    logic [31:0] es1 [2] = '{32'h25, 32'h7FFF_FFFF};
    logic [7:0]  es2 [2] = '{8'h25, 8'h80};
`endif
    logic [1:0]  ef1 [2] = '{2'b00, 2'b11};
    logic [1:0]  ef2 [2] = '{2'b00, 2'b10};
    logic [7:0]  xa2 [2] = '{8'd12, 8'h7F};
    logic [7:0]  xb2 [2] = '{8'd25, 8'h01};
    logic [33:0] res1;
    logic [9:0]  res2;
    int l, lat1, lat2;
    for (int i = 0; i < 2; i++) begin
      v1 = 1'b1; a1 = xa1[i]; b1 = xb1[i]; s1 = xs1[i]; r1 = 1'b1;
      v2 = 1'b1; a2 = xa2[i]; b2 = xb2[i]; s2 = 1'b0; r2 = 1'b1;
      @(posedge clk); #1;
      v1 = 1'b0; v2 = 1'b0;
      l = 1; lat1 = -1; lat2 = -1; res1 = 34'd0; res2 = 10'd0;
      while ((lat1 < 0 || lat2 < 0) && l < 10) begin
        if (lat1 < 0 && ov1) begin lat1 = l; res1 = {o1, c1, sum1}; end
        if (lat2 < 0 && ov2) begin lat2 = l; res2 = {o2, c2, sum2}; end
        @(posedge clk); #1;
        l++;
      end
      checks++;
      if (lat1 != 1 || res1 !== {ef1[i], es1[i]}) begin
        errors++;
        $display("FAIL s1_case[%0d]: got lat=%0d res=%h, want lat=1 res=%h", i, lat1, res1, {ef1[i], es1[i]});
      end
      checks++;
      if (lat2 != 2 || res2 !== {ef2[i], es2[i]}) begin
        errors++;
        $display("FAIL w8s2_case[%0d]: got lat=%0d res=%h, want lat=2 res=%h", i, lat2, res2, {ef2[i], es2[i]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = 32'd0; b = 32'd0; sub = 1'b0; out_ready = 1'b1;
    v1 = 1'b0; a1 = 32'd0; b1 = 32'd0; s1 = 1'b0; r1 = 1'b1;
    v2 = 1'b0; a2 = 8'd0; b2 = 8'd0; s2 = 1'b0; r2 = 1'b1;
    test_reset();
    test_flags();
    test_backpressure();
    test_streaming();
    test_reset_midstream();
    test_small_configs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Parametrised, pipelined two's-complement adder/subtractor.
- The carry chain is split into `STAGES` equal segments, one register stage per segment, so throughput stays at one operation per cycle at any `WIDTH`.
- Each result reports sum, carry-out and signed overflow, with the same flag semantics as the combinational adder family.
- It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides and full backpressure support.

## Interface
Parameters:
- `WIDTH`, 32, operand and result width in bits; must be ≥ 2.
- `STAGES`, 4, number of pipeline stages; must be ≥ 1, and `WIDTH % STAGES` must be 0. Segment width is `SEG = WIDTH/STAGES`.

Ports:
- `clk`  in  1  — the single clock; all state updates on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — operand transfer request.
- `in_ready`  out  1  — pipeline can accept operands this cycle.
- `a`  in  WIDTH  — operand A.
- `b`  in  WIDTH  — operand B.
- `sub`  in  1  — 0: A+B; 1: A−B, computed as A + ~B + 1.
- `out_valid`  out  1  — result present.
- `out_ready`  in  1  — consumer accepts the result.
- `sum`  out  WIDTH  — result.
- `carry_out`  out  1  — raw carry out of the MSB of A + B_eff + cin.
- `overflow`  out  1  — signed overflow flag.

## Operation
Input side:
- A transfer occurs on a rising edge where `in_valid && in_ready`.
- `B_eff = sub ? ~b : b` and `cin = sub`.

Per-stage behaviour:
- Stage k (0..STAGES−1) holds a valid bit, the partial sum bits [k*SEG +: SEG], the carry into the next segment, and the not-yet-added upper operand bits (skewed operand registers).
- Stage k adds its segment using the registered carry from stage k−1; stage 0 uses `cin`.

Final stage:
- `carry_out` = carry out of bit WIDTH−1.
- `overflow` = (a[MSB] == B_eff[MSB]) && (sum[MSB] != a[MSB]). The MSBs are carried through the pipeline.

Flow control:
- Stage k advances when it holds no data, or when stage k+1 advances.
- The last stage advances when `!out_valid || out_ready`.
- `in_ready` = stage 0 can advance. It is combinational from `out_ready` through the advance chain; there is no skid buffer.

Ordering and capacity:
- Results are delivered strictly in acceptance order; none are dropped or duplicated.
- Capacity is `STAGES` in-flight operations.

Width rules:
- All arithmetic is modulo 2^WIDTH; `carry_out` is bit WIDTH of the exact unsigned sum.
- For subtraction, `carry_out` = 1 means no borrow.

## Timing
- **Latency:** an operation accepted at edge N presents `out_valid` = 1 with its result after edge N+STAGES when unstalled. With `STAGES` = 1, the block is a registered adder with 1-cycle latency.
- **Throughput:** one result per cycle while `out_ready` is held high.
- **Stall:** while `out_valid && !out_ready`, `sum`, `carry_out` and `overflow` hold stable. Bubbles upstream of the stall still collapse.
- **Simultaneous events:** accept and deliver in the same cycle with a full pipeline is legal and sustains full rate.
- **Reset values:** while `rst` is high, all stage valid bits are 0 and `out_valid` = 0, `sum` = 0, `carry_out` = 0, `overflow` = 0. `in_ready` = 1 after reset deasserts.
- **Reset mid-operation:** all in-flight operations are discarded immediately (asynchronous). No partial result is ever emitted.

## Configuration
Macro `PIPE_ADDER_SAT_EN` enables saturation.
- **Defined:** when `overflow` = 1, `sum` is replaced in the final stage by 0111…1 if a[MSB] = 0, or 1000…0 if a[MSB] = 1. `overflow` still reports 1 and `carry_out` is unchanged (the raw carry). Latency is unchanged.
- **Undefined:** `sum` is always the wrapped modulo-2^WIDTH result.

## Test plan
Defaults are WIDTH = 32, STAGES = 4 unless stated.
1. **Positive overflow:** a = 0x7FFFFFFF, b = 0x1, sub = 0.
   - Result after 4 cycles: sum = 0x80000000, carry_out = 0, overflow = 1.
   - With `PIPE_ADDER_SAT_EN`: sum = 0x7FFFFFFF.
2. **Negative overflow:** a = 0xFFFFFFFF, b = 0x80000000.
   - Result: sum = 0x7FFFFFFF, carry_out = 1, overflow = 1.
   - With `PIPE_ADDER_SAT_EN`: sum = 0x80000000.
3. **Subtract and cross-segment carry:**
   - a = 2, b = 5, sub = 1 → sum = 0xFFFFFFFD, carry_out = 0, overflow = 0.
   - a = 0xFFFFFFFF, b = 1, sub = 0 → sum = 0, carry_out = 1, overflow = 0; the carry ripples through all 4 segments.
4. **Backpressure:** stream 8 operations (a = i, b = 0x10·i, i = 0..7) with out_ready = 0 for 10 cycles, then 1.
   - `in_ready` drops after exactly 4 acceptances.
   - Outputs hold stable during the stall.
   - All 8 results emerge in order with sum = 0x11·i.
5. **Full-rate streaming:** out_ready held at 1 and 100 random operations in back-to-back cycles.
   - One result per cycle after the initial 4-cycle latency.
   - Every result matches the reference model (a ± b, carry, overflow).
6. **Reset mid-stream:** assert `rst` with 3 operations in flight.
   - `out_valid` = 0 and all outputs = 0 immediately.
   - After release, no stale result appears, and a new 12 + 25 operation returns sum = 0x25 after 4 cycles.
   - Repeat the 12 + 25 check with STAGES = 1 (latency 1) and WIDTH = 8, STAGES = 2.
